// File: rtl/dmem_pkg.sv
// Shared constants for the data-side memory responder: register map offsets
// and STATUS bit positions.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'h1000_0000;

  // Word offsets within the register block (DataAdr[4:2])
  localparam logic [2:0] OFF_LED      = 3'd0;
  localparam logic [2:0] OFF_MTIME_LO = 3'd1;
  localparam logic [2:0] OFF_MTIME_HI = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  localparam int STAT_IRQ_BIT = 0;
  localparam int STAT_ERR_BIT = 1;

endpackage

// File: rtl/dmem_responder_mmio_timer.sv
// 64-bit free-running timer with coherent high-word snapshot, 32-bit compare
// and a sticky pending flag cleared by write-1-to-clear.
module mmio_timer
  import dmem_pkg::*;
#(
  parameter logic [63:0] MTIME_RST = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        snap,
  input  logic        cmp_we,
  input  logic [31:0] cmp_wdata,
  input  logic        irq_clr,
  input  logic [2:0]  rd_off,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [63:0] mtime_q, mtime_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] cmp_q, cmp_d;
  logic        pend_q, pend_d;

  always_comb begin
    mtime_d = mtime_q + 64'd1;
    hi_d    = snap ? mtime_q[63:32] : hi_q;
    cmp_d   = cmp_we ? cmp_wdata : cmp_q;
    // A match on the same edge as a clear keeps the flag set
    pend_d  = pend_q && !irq_clr;
    if ((cmp_q != 32'd0) && (mtime_q[31:0] == cmp_q)) pend_d = 1'b1;

    rdata = '0;
    case (rd_off)
      OFF_MTIME_LO: rdata = mtime_q[31:0];
      OFF_MTIME_HI: rdata = hi_q;
      OFF_MTIMECMP: rdata = cmp_q;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_q <= MTIME_RST;
      hi_q    <= '0;
      cmp_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      hi_q    <= hi_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
    end
  end

  assign irq = pend_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory target for the RV32 core: word RAM plus a small register
// block (LEDs, timer, sticky status). Combinational reads, clocked writes.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter logic [63:0] MTIME_RST = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic        timer_irq,
  output logic        addr_err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  logic [31:0]   mem_q [DEPTH];
  logic          ram_hit, mmio_hit;
  logic [AW-1:0] word_idx;
  logic [2:0]    off;
  logic          status_we, cmp_we, snap;
  logic [7:0]    leds_q, leds_d;
  logic          addr_err_q, addr_err_d;
  logic [31:0]   tmr_rdata;

  always_comb begin
    ram_hit   = (DataAdr < RAM_BYTES);
    mmio_hit  = !ram_hit && (DataAdr[31:5] == MMIO_BASE[31:5]);
    word_idx  = DataAdr[AW+1:2];
    off       = DataAdr[4:2];
    status_we = MemWrite && mmio_hit && (off == OFF_STATUS);
    cmp_we    = MemWrite && mmio_hit && (off == OFF_MTIMECMP);
    snap      = !MemWrite && mmio_hit && (off == OFF_MTIME_LO);

    leds_d = leds_q;
    if (MemWrite && mmio_hit && (off == OFF_LED)) leds_d = WriteData[7:0];

    addr_err_d = addr_err_q;
    if (status_we && WriteData[STAT_ERR_BIT]) addr_err_d = 1'b0;
    if (MemWrite && !ram_hit && !mmio_hit)    addr_err_d = 1'b1;

    ReadData = '0;
    if (ram_hit) begin
      ReadData = mem_q[word_idx];
    end else if (mmio_hit) begin
      case (off)
        OFF_LED:                                  ReadData = {24'd0, leds_q};
        OFF_MTIME_LO, OFF_MTIME_HI, OFF_MTIMECMP: ReadData = tmr_rdata;
        OFF_STATUS: begin
          ReadData[STAT_IRQ_BIT] = timer_irq;
          ReadData[STAT_ERR_BIT] = addr_err_q;
        end
        default:                                  ReadData = '0;
      endcase
    end
  end

  // RAM keeps its contents through reset; a store landing on a reset edge is dropped
  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit && reset) mem_q[word_idx] <= WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      leds_q     <= leds_d;
      addr_err_q <= addr_err_d;
    end
  end

  mmio_timer #(
    .MTIME_RST (MTIME_RST)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .snap      (snap),
    .cmp_we    (cmp_we),
    .cmp_wdata (WriteData),
    .irq_clr   (status_we && WriteData[STAT_IRQ_BIT]),
    .rd_off    (off),
    .rdata     (tmr_rdata),
    .irq       (timer_irq)
  );

  assign leds     = leds_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table for RAM/MMIO decode plus
// hand sequences for timer, interrupt, snapshot and reset behaviour.
module tb_dmem_responder;

  localparam logic [31:0] B = 32'h1000_0000;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr, WriteData, ReadData;
  logic [7:0]  leds;
  logic        timer_irq, addr_err;

  logic        we2;
  logic [31:0] adr2, wd2, rd2;
  logic [7:0]  leds2;
  logic        irq2, err2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  dmem_responder dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .leds(leds),
    .timer_irq(timer_irq), .addr_err(addr_err)
  );

  // Second instance starts its timer close to a 32-bit carry
  dmem_responder #(.MTIME_RST(64'h0000_0001_FFFF_FF00)) dut2 (
    .clk(clk), .reset(reset), .MemWrite(we2), .DataAdr(adr2),
    .WriteData(wd2), .ReadData(rd2), .leds(leds2),
    .timer_irq(irq2), .addr_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] rd;
    logic [7:0]  leds;
    logic        err;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = we;
    DataAdr   = a;
    WriteData = d;
    #3;
  endtask

  task automatic cycle_end();
    @(posedge clk);
    if (reset) cyc++;
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h10,        32'hDEADBEEF, 1'b0, 32'h0,        8'h00, 1'b0};
    tbl[1]  = '{1'b0, 32'h10,        32'h0,        1'b1, 32'hDEADBEEF, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 32'h13,        32'h0,        1'b1, 32'hDEADBEEF, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 32'h14,        32'h11111111, 1'b0, 32'h0,        8'h00, 1'b0};
    tbl[4]  = '{1'b1, 32'h14,        32'h22222222, 1'b1, 32'h11111111, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 32'h14,        32'h0,        1'b1, 32'h22222222, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, B + 32'h00,    32'h123456A5, 1'b1, 32'h0,        8'h00, 1'b0};
    tbl[7]  = '{1'b0, B + 32'h00,    32'h0,        1'b1, 32'h000000A5, 8'hA5, 1'b0};
    tbl[8]  = '{1'b1, 32'h2000_0000, 32'h5,        1'b1, 32'h0,        8'hA5, 1'b0};
    tbl[9]  = '{1'b0, 32'h2000_0000, 32'h0,        1'b1, 32'h0,        8'hA5, 1'b1};
    tbl[10] = '{1'b0, B + 32'h10,    32'h0,        1'b1, 32'h2,        8'hA5, 1'b1};
    tbl[11] = '{1'b1, B + 32'h10,    32'h2,        1'b1, 32'h2,        8'hA5, 1'b1};
    tbl[12] = '{1'b0, B + 32'h10,    32'h0,        1'b1, 32'h0,        8'hA5, 1'b0};
    tbl[13] = '{1'b1, B + 32'h18,    32'hFFFFFFFF, 1'b1, 32'h0,        8'hA5, 1'b0};
    tbl[14] = '{1'b0, B + 32'h18,    32'h0,        1'b1, 32'h0,        8'hA5, 1'b0};
    tbl[15] = '{1'b1, B + 32'h04,    32'hFFFFFFFF, 1'b0, 32'h0,        8'hA5, 1'b0};
    tbl[16] = '{1'b0, B + 32'h10,    32'h0,        1'b1, 32'h0,        8'hA5, 1'b0};
    tbl[17] = '{1'b0, B + 32'h0C,    32'h0,        1'b1, 32'h0,        8'hA5, 1'b0};
    tbl[18] = '{1'b1, B + 32'h0C,    32'h000055AA, 1'b1, 32'h0,        8'hA5, 1'b0};
    tbl[19] = '{1'b0, B + 32'h0C,    32'h0,        1'b1, 32'h000055AA, 8'hA5, 1'b0};
    tbl[20] = '{1'b1, 32'hFC,        32'hCAFEF00D, 1'b0, 32'h0,        8'hA5, 1'b0};
    tbl[21] = '{1'b0, 32'hFC,        32'h0,        1'b1, 32'hCAFEF00D, 8'hA5, 1'b0};
    tbl[22] = '{1'b0, 32'h100,       32'h0,        1'b1, 32'h0,        8'hA5, 1'b0};
    tbl[23] = '{1'b0, B + 32'h08,    32'h0,        1'b1, 32'h0,        8'hA5, 1'b0};

    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    we2 = 1'b0; adr2 = '0; wd2 = '0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_leds", {24'd0, leds}, 32'h0);
    chk("rst_irq", {31'd0, timer_irq}, 32'h0);
    chk("rst_err", {31'd0, addr_err}, 32'h0);
    DataAdr = B + 32'h0C; #1;
    chk("rst_cmp", ReadData, 32'h0);
    DataAdr = B + 32'h08; #1;
    chk("rst_hi", ReadData, 32'h0);

    @(posedge clk); #1;
    reset = 1'b1; cyc = 0;
    drive(1'b0, B + 32'h04, 32'h0);
    chk("mtime_first", ReadData, 32'd0);
    cycle_end();
    drive(1'b0, B + 32'h04, 32'h0);
    chk("mtime_second", ReadData, 32'd1);
    cycle_end();

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].adr, tbl[i].wd);
      if (tbl[i].chk) chk($sformatf("vec%0d_rd", i), ReadData, tbl[i].rd);
      chk($sformatf("vec%0d_leds", i), {24'd0, leds}, {24'd0, tbl[i].leds});
      chk($sformatf("vec%0d_err", i), {31'd0, addr_err}, {31'd0, tbl[i].err});
      chk($sformatf("vec%0d_irq", i), {31'd0, timer_irq}, 32'h0);
      cycle_end();
    end

    // Compare match at mtime=100 raises irq one cycle later
    drive(1'b1, B + 32'h0C, 32'd100);
    cycle_end();
    drive(1'b0, 32'h0, 32'h0);
    repeat (100 - cyc) cycle_end();
    drive(1'b0, 32'h0, 32'h0);
    chk("irq_match_cycle", {31'd0, timer_irq}, 32'h0);
    cycle_end();
    drive(1'b1, B + 32'h10, 32'h1);
    chk("irq_after_match", {31'd0, timer_irq}, 32'h1);
    chk("status_irq_rd", ReadData, 32'h1);
    cycle_end();
    drive(1'b1, B + 32'h0C, 32'd110);
    chk("irq_cleared", {31'd0, timer_irq}, 32'h0);
    cycle_end();
    drive(1'b0, 32'h0, 32'h0);
    repeat (110 - cyc) cycle_end();
    drive(1'b1, B + 32'h10, 32'h1);
    chk("irq_pre_setwins", {31'd0, timer_irq}, 32'h0);
    cycle_end();
    drive(1'b1, B + 32'h10, 32'h1);
    chk("irq_set_wins", {31'd0, timer_irq}, 32'h1);
    cycle_end();
    drive(1'b1, B + 32'h0C, 32'h0);
    chk("irq_cleared2", {31'd0, timer_irq}, 32'h0);
    cycle_end();

    // Coherent LO/HI pair across the 32-bit carry on the second instance
    drive(1'b0, 32'h0, 32'h0);
    repeat (255 - cyc) cycle_end();
    adr2 = B + 32'h04;
    drive(1'b0, 32'h0, 32'h0);
    chk("pair_lo", rd2, 32'hFFFF_FFFF);
    cycle_end();
    adr2 = B + 32'h08;
    drive(1'b0, 32'h0, 32'h0);
    chk("pair_hi", rd2, 32'h0000_0001);
    chk("dut2_quiet", {22'd0, leds2, irq2, err2}, 32'h0);
    cycle_end();
    adr2 = '0;

    // Mid-run reset: registers clear, RAM survives, in-flight store dropped
    drive(1'b1, 32'h14, 32'h55);
    cycle_end();
    drive(1'b1, B + 32'h00, 32'hFF);
    cycle_end();
    drive(1'b0, 32'h0, 32'h0);
    repeat (500 - cyc) cycle_end();
    drive(1'b0, B + 32'h04, 32'h0);
    chk("mtime_500", ReadData, 32'd500);
    chk("leds_pre_rst", {24'd0, leds}, 32'hFF);
    reset = 1'b0;
    #1;
    chk("leds_async_rst", {24'd0, leds}, 32'h0);
    drive(1'b1, 32'h14, 32'h99);
    cycle_end();
    reset = 1'b1; cyc = 0;
    drive(1'b0, B + 32'h04, 32'h0);
    chk("mtime_restart0", ReadData, 32'd0);
    cycle_end();
    drive(1'b0, B + 32'h04, 32'h0);
    chk("mtime_restart1", ReadData, 32'd1);
    cycle_end();
    drive(1'b0, 32'h14, 32'h0);
    chk("ram_retained", ReadData, 32'h55);
    cycle_end();
    drive(1'b0, B + 32'h00, 32'h0);
    chk("led_rd_after_rst", ReadData, 32'h0);
    cycle_end();
    drive(1'b0, B + 32'h0C, 32'h0);
    chk("cmp_after_rst", ReadData, 32'h0);
    cycle_end();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
